// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Inter-stage pipeline register with a valid/ready handshake and a 2-entry
//   skid buffer. The payload is opaque; field packing belongs to the stages on
//   either side. The occupancy is encoded directly by the two valid bits.
//   in_ready comes straight from a register, so out_ready has no
//   combinational path to in_ready.
//
// Optional feature macro: PIPE_FWD_TAP_EN
//   When defined, this block adds a forwarding tap (fwd_valid/fwd_dst/fwd_data)
//   that is driven combinationally from the output register.
//
// Ports
//   clk        pipeline clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, drops every held entry and zeroes the data
//   in_valid   upstream has a payload
//   in_data    upstream payload [DATA_W]
//   in_ready   stage can accept this cycle
//   out_valid  payload available downstream
//   out_data   oldest held payload [DATA_W]
//   out_ready  downstream consumes this cycle (0 = stall)
//   occ        entries held, 0..2
//   fwd_valid  (PIPE_FWD_TAP_EN) copy of out_valid
//   fwd_dst    (PIPE_FWD_TAP_EN) destination field of out_data [DST_W]
//   fwd_data   (PIPE_FWD_TAP_EN) copy of out_data [DATA_W]
module pipe_stage_skid #(
  parameter int DATA_W  = 42,
  parameter int DST_W   = 3,
  parameter int DST_LSB = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ
`ifdef PIPE_FWD_TAP_EN
  ,
  output logic              fwd_valid,
  output logic [DST_W-1:0]  fwd_dst,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // The destination field must sit inside the payload. A bad setting fails
  // elaboration because the instantiated module below does not exist.
  if (DST_LSB + DST_W > DATA_W) begin : g_dst_field_out_of_range
    pipe_stage_skid_dst_field_out_of_range u_bad_cfg ();
  end

  logic              vld_p0;
  logic              skid_vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] skid_data_p0;

  logic              vld_nxt;
  logic              skid_vld_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] skid_data_nxt;

  logic              accept;
  logic              consume;

  assign accept  = in_valid & in_ready;
  assign consume = vld_p0 & out_ready;

  // ---- stage p0: output register and skid entry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      skid_vld_p0  <= 1'b0;
      data_p0      <= '0;
      skid_data_p0 <= '0;
    end else begin
      vld_p0       <= vld_nxt;
      skid_vld_p0  <= skid_vld_nxt;
      data_p0      <= data_nxt;
      skid_data_p0 <= skid_data_nxt;
    end
  end

  always_comb begin
    vld_nxt       = vld_p0;
    skid_vld_nxt  = skid_vld_p0;
    data_nxt      = data_p0;
    skid_data_nxt = skid_data_p0;
    if (flush) begin
      vld_nxt       = 1'b0;
      skid_vld_nxt  = 1'b0;
      data_nxt      = '0;
      skid_data_nxt = '0;
    end else begin
      unique case ({vld_p0, skid_vld_p0})
        2'b00: begin
          if (accept) begin
            vld_nxt  = 1'b1;
            data_nxt = in_data;
          end
        end
        2'b10: begin
          if (accept && consume) begin
            data_nxt = in_data;
          end else if (accept) begin
            skid_vld_nxt  = 1'b1;
            skid_data_nxt = in_data;
          end else if (consume) begin
            vld_nxt = 1'b0;
          end
        end
        2'b11: begin
          if (consume) begin
            skid_vld_nxt = 1'b0;
            data_nxt     = skid_data_p0;
          end
        end
        default: begin
          // A skid entry without an output entry cannot be reached; recover
          // to empty rather than hold an inconsistent state.
          vld_nxt      = 1'b0;
          skid_vld_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = ~skid_vld_p0;
    out_valid = vld_p0;
    out_data  = data_p0;
    occ       = {vld_p0 & skid_vld_p0, vld_p0 ^ skid_vld_p0};
  end

`ifdef PIPE_FWD_TAP_EN
  assign fwd_valid = vld_p0;
  assign fwd_dst   = data_p0[DST_LSB +: DST_W];
  assign fwd_data  = data_p0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DATA_W  = 42;
  localparam int DST_W   = 3;
  localparam int DST_LSB = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occ;
`ifdef PIPE_FWD_TAP_EN
  logic              fwd_valid;
  logic [DST_W-1:0]  fwd_dst;
  logic [DATA_W-1:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: an ordered list of held payloads, capacity two, plus the
  // value the output shows when nothing is held.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] last_out;

  pipe_stage_skid #(.DATA_W(DATA_W), .DST_W(DST_W), .DST_LSB(DST_LSB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occ(occ)
`ifdef PIPE_FWD_TAP_EN
    , .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DATA_W-1:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : last_out;
    chk({tag, "/out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, "/out_data"},  64'(out_data),  64'(exp_d));
    chk({tag, "/occ"},       64'(occ),       64'(q.size()));
    chk({tag, "/in_ready"},  64'(in_ready),  64'(q.size() < 2));
`ifdef PIPE_FWD_TAP_EN
    chk({tag, "/fwd_valid"}, 64'(fwd_valid), 64'(q.size() > 0));
    chk({tag, "/fwd_dst"},   64'(fwd_dst),   64'(exp_d[DST_LSB +: DST_W]));
    chk({tag, "/fwd_data"},  64'(fwd_data),  64'(exp_d));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    last_out = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                      input logic fl, input string tag);
    bit acc, cons;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc  = iv && (q.size() < 2);
    cons = ordy && (q.size() > 0);
    if (fl) begin
      model_reset();
    end else begin
      if (cons) last_out = q.pop_front();
      if (acc) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0]       r;
    logic [DATA_W-1:0] pay;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");
    step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Streaming with out_ready high
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DATA_W'(i), 1'b1, 1'b0, "stream");
      chk("stream/latency", 64'(out_data), 64'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0, "stream_drain");
    chk("drain/holds_last", 64'(out_data), 64'd4);

    // Stall into skid, then release
    step(1'b1, DATA_W'('hA), 1'b0, 1'b0, "stall_a");
    step(1'b1, DATA_W'('hB), 1'b0, 1'b0, "stall_b");
    chk("stall/occ_full", 64'(occ), 64'd2);
    step(1'b1, DATA_W'('hC), 1'b0, 1'b0, "stall_blocked");
    step(1'b0, '0, 1'b1, 1'b0, "release_1");
    chk("release/second", 64'(out_data), 64'hB);
    step(1'b0, '0, 1'b1, 1'b0, "release_2");

    // Flush colliding with accept and consume in FULL
    step(1'b1, DATA_W'('h11), 1'b0, 1'b0, "fill_1");
    step(1'b1, DATA_W'('h22), 1'b0, 1'b0, "fill_2");
    step(1'b1, DATA_W'('h33), 1'b1, 1'b1, "flush");
    chk("flush/data_zero", 64'(out_data), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, "post_flush");

    // Asynchronous reset between edges while FULL
    step(1'b1, DATA_W'('h44), 1'b0, 1'b0, "fill_3");
    step(1'b1, DATA_W'('h55), 1'b0, 1'b0, "fill_4");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, DATA_W'('h5), 1'b1, 1'b0, "after_reset");
    chk("after_reset/data", 64'(out_data), 64'h5);
    step(1'b0, '0, 1'b1, 1'b0, "after_reset_drain");

    // Destination field 3'b101 at bits [34:32]
    pay = '0;
    pay[DST_LSB +: DST_W] = 3'b101;
    pay[7:0] = 8'h3C;
    step(1'b1, pay, 1'b0, 1'b0, "fwd_load");
`ifdef PIPE_FWD_TAP_EN
    chk("fwd/dst_5", 64'(fwd_dst), 64'd5);
    chk("fwd/valid", 64'(fwd_valid), 64'd1);
`endif
    step(1'b0, '0, 1'b1, 1'b0, "fwd_consume");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      step(($urandom_range(0, 3) != 0), r[DATA_W-1:0], ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (MEM/WB style).
- Carries an opaque payload between two pipeline stages using a valid/ready handshake and a 2-entry skid buffer.
- Supports backpressure (stall), synchronous flush and deterministic zeroed state after reset.
- Instantiated between any two stages (EX/MEM, MEM/WB, ...). Field packing is done by the instantiating stage.

Parameters:
DATA_W, 42, payload width in bits (includes control bits and result fields).
DST_W, 3, width of destination-register field; used only by the forwarding tap.
DST_LSB, 32, bit position of the destination field inside the payload.

Ports:
clk  in  1  pipeline clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush; drops all held entries.
in_valid  in  1  upstream has a payload.
in_data  in  DATA_W  upstream payload.
in_ready  out  1  stage can accept this cycle.
out_valid  out  1  payload available downstream.
out_data  out  DATA_W  oldest held payload.
out_ready  in  1  downstream consumes this cycle (0 = stall).
occ  out  2  entries held (0..2).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid valid=0, out_data=0, skid data=0, occ=0, in_ready=1. No state reset on flush, other than as listed below.
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready is a register output equal to ~skid_valid, so there is no combinational path from out_ready.
- State is encoded by the valid bits:
  - EMPTY: out_v=0, skid_v=0.
  - ONE: out_v=1, skid_v=0.
  - FULL: out_v=1, skid_v=1.
- EMPTY transitions:
  - accept -> ONE, out_data<=in_data.
  - else stay.
- ONE transitions:
  - accept & consume -> ONE, out_data<=in_data.
  - accept & ~consume -> FULL, skid<=in_data.
  - ~accept & consume -> EMPTY.
  - else hold.
- FULL transitions:
  - consume -> ONE, out_data<=skid.
  - else hold. in_ready=0 in FULL, so no accept occurs.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N is on out_data after edge N.
  - Sustained throughput is 1/cycle with out_ready held high.
- Ordering: strict FIFO; no payload is duplicated or dropped except by flush.
- Flush has priority over all handshakes at the same edge:
  - Next state is EMPTY, both data registers are zeroed, occ=0.
  - An input accepted in the flush cycle is discarded.
  - A consume in the flush cycle still counts as delivered downstream.
- While out_valid=0, out_data is held at 0 (after reset or flush) or at the last consumed payload (after drain). Downstream must qualify out_data with out_valid.
- occ = out_v + skid_v, updated on the same edge as the valid bits.
- rst_n asserted mid-transfer discards everything immediately. The first accept is allowed on the first posedge after release.

Optional Feature:
- Macro: PIPE_FWD_TAP_EN.
- When defined, three extra outputs are added:
  - fwd_valid (1): equal to out_valid.
  - fwd_dst (DST_W): out_data[DST_LSB+DST_W-1:DST_LSB].
  - fwd_data (DATA_W): equal to out_data.
- All three are combinational from the out register, for the forwarding unit, and read 0 after reset and after flush.
- When not defined, these ports and their logic are absent. The core behaviour is identical either way.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles then 1, in_valid=0 -> out_valid=0, out_data=0, occ=0, in_ready=1.
- Streaming: in_data=1,2,3,4 on consecutive cycles with out_ready=1 -> out_data=1,2,3,4 one cycle later each, occ stays 1, in_ready stays 1.
- Stall into skid:
  - Stimulus: send 0xA then 0xB with out_ready=0.
  - Response: occ=2, in_ready=0, out_data=0xA held.
  - Then raise out_ready: out 0xA, then 0xB, occ 2->1->0.
- Flush collision: in FULL state assert flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle out_valid=0, occ=0, out_data=0, in_ready=1, and the input payload never appears.
- Async reset mid-stall: in FULL state drop rst_n between clock edges -> out_valid falls before the next posedge; after release, accepting 0x5 gives out_data=0x5 one cycle later.
- PIPE_FWD_TAP_EN: with DST_LSB=32, send payload with bits[34:32]=3'b101 -> fwd_valid=1, fwd_dst=5 in the same cycle out_valid rises; fwd_valid=0 after consume.
